// File: rtl/alarm_controller.sv
// Alarm clock sequencer: rings on a rising time match, supports snooze/stop, auto-stops after a timeout.
// Latency: outputs are registered Moore decodes of state, one cycle after the input. No backpressure; pulses are taken when sampled.
module alarm_controller #(
    parameter int unsigned SNOOZE_SECS       = 540,
    parameter int unsigned RING_TIMEOUT_SECS = 300,
    parameter int unsigned MAX_SNOOZES       = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ALARM_EN,
    input  logic       SEC_TICK,
    input  logic       SNOOZE,
    input  logic       STOP,
    input  logic [3:0] TIME_HOURS,
    input  logic [5:0] TIME_MINS,
    input  logic       TIME_AM_PM,
    input  logic [3:0] ALARM_HOURS,
    input  logic [5:0] ALARM_MINS,
    input  logic       ALARM_AM_PM,
    output logic       ALARM_OUT,
    output logic       SNOOZE_ACTIVE,
    output logic [1:0] STATE_OUT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZING = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [11:0] SNOOZE_LD = 12'(SNOOZE_SECS);
    localparam logic [11:0] RING_LD   = 12'(RING_TIMEOUT_SECS);
    localparam logic [3:0]  SNOOZE_MAX = 4'(MAX_SNOOZES);

    state_t      state, state_nxt;
    logic [11:0] ring_tmr, ring_tmr_nxt;
    logic [11:0] snz_tmr, snz_tmr_nxt;
    logic [3:0]  used, used_nxt;
    logic        match, match_q, trigger;

    assign match   = (TIME_HOURS == ALARM_HOURS) && (TIME_MINS == ALARM_MINS) &&
                     (TIME_AM_PM == ALARM_AM_PM);
    assign trigger = match && !match_q;

    always_comb begin
        state_nxt    = state;
        ring_tmr_nxt = ring_tmr;
        snz_tmr_nxt  = snz_tmr;
        used_nxt     = used;
        case (state)
            IDLE: begin
                if (trigger && ALARM_EN) begin
                    state_nxt    = RINGING;
                    ring_tmr_nxt = RING_LD;
                    used_nxt     = 4'd0;
                end
            end
            RINGING: begin
                if (!ALARM_EN) begin
                    state_nxt = IDLE;
                end else if (STOP) begin
                    state_nxt = DONE;
                end else if (SNOOZE && (used < SNOOZE_MAX)) begin
                    state_nxt   = SNOOZING;
                    snz_tmr_nxt = SNOOZE_LD;
                    used_nxt    = used + 4'd1;
                end else if (SEC_TICK) begin
                    // Timer reaching 1 ends the ring, so it never counts below 1.
                    if (ring_tmr <= 12'd1) state_nxt = DONE;
                    else                   ring_tmr_nxt = ring_tmr - 12'd1;
                end
            end
            SNOOZING: begin
                if (!ALARM_EN) begin
                    state_nxt = IDLE;
                end else if (STOP) begin
                    state_nxt = DONE;
                end else if (SEC_TICK) begin
                    if (snz_tmr <= 12'd1) begin
                        state_nxt    = RINGING;
                        ring_tmr_nxt = RING_LD;
                    end else begin
                        snz_tmr_nxt = snz_tmr - 12'd1;
                    end
                end
            end
            DONE: begin
                // Held until the matching minute passes so the same minute cannot re-ring.
                if (!ALARM_EN || !match) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ring_tmr      <= 12'd0;
            snz_tmr       <= 12'd0;
            used          <= 4'd0;
            match_q       <= 1'b1;
            ALARM_OUT     <= 1'b0;
            SNOOZE_ACTIVE <= 1'b0;
            STATE_OUT     <= 2'd0;
        end else begin
            state         <= state_nxt;
            ring_tmr      <= ring_tmr_nxt;
            snz_tmr       <= snz_tmr_nxt;
            used          <= used_nxt;
            match_q       <= match;
            ALARM_OUT     <= (state_nxt == RINGING);
            SNOOZE_ACTIVE <= (state_nxt == SNOOZING);
            STATE_OUT     <= state_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short timer parameters.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ALARM_EN, SEC_TICK, SNOOZE, STOP;
    logic [3:0] TIME_HOURS, ALARM_HOURS;
    logic [5:0] TIME_MINS, ALARM_MINS;
    logic       TIME_AM_PM, ALARM_AM_PM;
    logic       ALARM_OUT, SNOOZE_ACTIVE;
    logic [1:0] STATE_OUT;

    int checks = 0;
    int errors = 0;

    alarm_controller #(
        .SNOOZE_SECS(5),
        .RING_TIMEOUT_SECS(4),
        .MAX_SNOOZES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ALARM_EN(ALARM_EN),
        .SEC_TICK(SEC_TICK),
        .SNOOZE(SNOOZE),
        .STOP(STOP),
        .TIME_HOURS(TIME_HOURS),
        .TIME_MINS(TIME_MINS),
        .TIME_AM_PM(TIME_AM_PM),
        .ALARM_HOURS(ALARM_HOURS),
        .ALARM_MINS(ALARM_MINS),
        .ALARM_AM_PM(ALARM_AM_PM),
        .ALARM_OUT(ALARM_OUT),
        .SNOOZE_ACTIVE(SNOOZE_ACTIVE),
        .STATE_OUT(STATE_OUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all three outputs together: alarm, snooze_active, state.
    task automatic chk_out(input string tag, input logic a, input logic s, input logic [1:0] st);
        chk({tag, ".alarm"}, 32'(ALARM_OUT), 32'(a));
        chk({tag, ".snooze"}, 32'(SNOOZE_ACTIVE), 32'(s));
        chk({tag, ".state"}, 32'(STATE_OUT), 32'(st));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic pm);
        TIME_HOURS = h;
        TIME_MINS  = m;
        TIME_AM_PM = pm;
    endtask

    task automatic tick();
        SEC_TICK = 1'b1;
        step();
        SEC_TICK = 1'b0;
    endtask

    task automatic snooze();
        SNOOZE = 1'b1;
        step();
        SNOOZE = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ALARM_EN = 1'b1; SEC_TICK = 1'b0; SNOOZE = 1'b0; STOP = 1'b0;
        ALARM_HOURS = 4'd7; ALARM_MINS = 6'd30; ALARM_AM_PM = 1'b0;
        set_time(4'd7, 6'd29, 1'b0);
        #3;
        chk_out("reset", 1'b0, 1'b0, 2'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk_out("idle_pre", 1'b0, 1'b0, 2'd0);

        // Basic trigger and ring timeout.
        set_time(4'd7, 6'd30, 1'b0);
        step();
        chk_out("trigger", 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) tick();
        chk_out("ring_3ticks", 1'b1, 1'b0, 2'd1);
        tick();
        chk_out("ring_timeout", 1'b0, 1'b0, 2'd3);
        step();
        chk_out("done_hold", 1'b0, 1'b0, 2'd3);
        set_time(4'd7, 6'd31, 1'b0);
        step();
        chk_out("done_exit", 1'b0, 1'b0, 2'd0);

        // Snooze cycle, snooze limit, ring timer reload.
        set_time(4'd7, 6'd30, 1'b0);
        step();
        chk_out("trig2", 1'b1, 1'b0, 2'd1);
        snooze();
        chk_out("snooze1", 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) tick();
        chk_out("snooze1_4ticks", 1'b0, 1'b1, 2'd2);
        tick();
        chk_out("snooze1_end", 1'b1, 1'b0, 2'd1);
        snooze();
        chk_out("snooze2", 1'b0, 1'b1, 2'd2);
        snooze();
        chk_out("snooze_in_snz", 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 5; i++) tick();
        chk_out("snooze2_end", 1'b1, 1'b0, 2'd1);
        snooze();
        chk_out("snooze3_ignored", 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) tick();
        chk_out("reload_3ticks", 1'b1, 1'b0, 2'd1);
        tick();
        chk_out("reload_timeout", 1'b0, 1'b0, 2'd3);
        set_time(4'd7, 6'd31, 1'b0);
        step();
        chk_out("idle2", 1'b0, 1'b0, 2'd0);

        // STOP beats SNOOZE; no re-ring within the same matching minute.
        set_time(4'd7, 6'd30, 1'b0);
        step();
        chk_out("trig3", 1'b1, 1'b0, 2'd1);
        STOP = 1'b1; SNOOZE = 1'b1;
        step();
        STOP = 1'b0; SNOOZE = 1'b0;
        chk_out("stop_snooze", 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++) step();
        chk_out("no_rering", 1'b0, 1'b0, 2'd3);
        ALARM_EN = 1'b0;
        step();
        chk_out("en_off_done", 1'b0, 1'b0, 2'd0);
        ALARM_EN = 1'b1;
        step();
        step();
        chk_out("en_on_no_ring", 1'b0, 1'b0, 2'd0);
        set_time(4'd7, 6'd31, 1'b0);
        step();
        set_time(4'd7, 6'd30, 1'b0);
        step();
        chk_out("rematch", 1'b1, 1'b0, 2'd1);
        ALARM_EN = 1'b0;
        step();
        chk_out("en_off_ring", 1'b0, 1'b0, 2'd0);

        // AM/PM mismatch and disabled alarm at trigger.
        ALARM_EN = 1'b1;
        set_time(4'd7, 6'd29, 1'b1);
        step();
        set_time(4'd7, 6'd30, 1'b1);
        step();
        chk_out("pm_mismatch", 1'b0, 1'b0, 2'd0);
        ALARM_EN = 1'b0;
        set_time(4'd7, 6'd29, 1'b0);
        step();
        set_time(4'd7, 6'd30, 1'b0);
        step();
        chk_out("en_off_trig", 1'b0, 1'b0, 2'd0);
        ALARM_EN = 1'b1;
        step();
        chk_out("en_late", 1'b0, 1'b0, 2'd0);

        // Asynchronous reset mid-snooze, released while time matches.
        set_time(4'd7, 6'd31, 1'b0);
        step();
        set_time(4'd7, 6'd30, 1'b0);
        step();
        snooze();
        chk_out("pre_reset_snz", 1'b0, 1'b1, 2'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0, 2'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_out("reset_rel_match", 1'b0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter SNOOZE_SECS, default 540, snooze length in SEC_TICK pulses (legal 1..4095).
REQ-002 SHALL have parameter RING_TIMEOUT_SECS, default 300, ring auto-stop length in SEC_TICK pulses (legal 1..4095).
REQ-003 SHALL have parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event (legal 0..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ALARM_EN  input  1  level; alarm armed when 1.
REQ-007 SEC_TICK  input  1  one-cycle pulse, once per second.
REQ-008 SNOOZE  input  1  one-cycle request pulse.
REQ-009 STOP  input  1  one-cycle request pulse.
REQ-010 TIME_HOURS  input  4  current hour, 0-11.
REQ-011 TIME_MINS  input  6  current minute, 0-59.
REQ-012 TIME_AM_PM  input  1  current half-day, 0=AM, 1=PM.
REQ-013 ALARM_HOURS / ALARM_MINS / ALARM_AM_PM  input  4 / 6 / 1  alarm setting, same encoding as current time.
REQ-014 ALARM_OUT  output  1  buzzer drive.
REQ-015 SNOOZE_ACTIVE  output  1  high while snoozing.
REQ-016 STATE_OUT  output  2  FSM state: 0 IDLE, 1 RINGING, 2 SNOOZING, 3 DONE.

Function
REQ-017 match SHALL be combinational: all three time fields equal the alarm fields bit-for-bit; no range check.
REQ-018 match_q SHALL register match each cycle; a trigger is match=1 and match_q=0.
REQ-019 All outputs SHALL be registered and decoded from state (Moore): ALARM_OUT=1 only in RINGING, SNOOZE_ACTIVE=1 only in SNOOZING.
REQ-020 IDLE: trigger with ALARM_EN=1 -> RINGING; ring timer loaded with RING_TIMEOUT_SECS; snooze-used count cleared to 0.
REQ-021 RINGING priority, highest first: ALARM_EN=0 -> IDLE; STOP -> DONE; SNOOZE with used<MAX_SNOOZES -> SNOOZING, snooze timer loaded with SNOOZE_SECS, used+1; SEC_TICK with ring timer=1 -> DONE; SEC_TICK otherwise decrements ring timer.
REQ-022 SNOOZE in RINGING with used=MAX_SNOOZES SHALL be ignored; ringing continues.
REQ-023 SNOOZING priority: ALARM_EN=0 -> IDLE; STOP -> DONE; SEC_TICK with snooze timer=1 -> RINGING, ring timer reloaded with RING_TIMEOUT_SECS; SEC_TICK otherwise decrements; SNOOZE ignored.
REQ-024 DONE: ALARM_EN=0 or match=0 -> IDLE; prevents re-trigger in the same matching minute.
REQ-025 Same-cycle STOP and SNOOZE SHALL resolve to STOP.
REQ-026 Triggers in RINGING, SNOOZING or DONE SHALL be ignored.
REQ-027 Timers SHALL be 12-bit unsigned and never wrap below 1 while counting.
REQ-028 Latency: the state change and output change SHALL appear on the edge that samples the causing input; outputs are visible one cycle after the input is presented.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, ALARM_OUT=0, SNOOZE_ACTIVE=0, STATE_OUT=0, timers=0, snooze-used=0, match_q=1.
REQ-030 Because match_q resets to 1, reset released while time equals alarm time SHALL NOT ring until match next rises.
REQ-031 Reset asserted mid-RINGING or mid-SNOOZING SHALL silence outputs asynchronously, without waiting for clk.

Verification (SNOOZE_SECS=5, RING_TIMEOUT_SECS=4, MAX_SNOOZES=2)
REQ-032 Alarm 7:30 AM, ALARM_EN=1, time steps 7:29 to 7:30 AM -> next cycle ALARM_OUT=1, STATE_OUT=1; after 4 SEC_TICKs -> STATE_OUT=3, ALARM_OUT=0; time 7:31 -> STATE_OUT=0.
REQ-033 Ringing, SNOOZE pulse -> SNOOZE_ACTIVE=1, ALARM_OUT=0; 5th SEC_TICK -> ALARM_OUT=1 again; repeat -> third SNOOZE ignored, ALARM_OUT stays 1.
REQ-034 Ringing, STOP and SNOOZE in the same cycle -> STATE_OUT=3; with time held at 7:30, no re-ring; ALARM_EN cycled 0 then 1 -> still no ring until match rises again.
REQ-035 Time 7:30 PM with alarm 7:30 AM -> no ring (AM/PM mismatch); ALARM_EN=0 at trigger -> no ring.
REQ-036 reset_n pulsed low mid-snooze -> outputs 0 without clk; released with time=alarm -> stays IDLE.
